plot_capture: RTL and testbench
===============================

// Module: plot_capture
// PURPOSE
//   Receiving end of the pixel-plot interface driven by the drawing engines (vga_x/vga_y/vga_colour/vga_plot).
//   - Stores every accepted plot into an on-chip WIDTHxHEIGHT x 3-bit framebuffer.
//   - Offers a random-access readback port and a start/done clear sequencer.
//   - Used as the pixel sink behind the drawing blocks, and as the scoreboard target in benches.
// PARAMETERS
//   WIDTH         160     visible columns; x >= WIDTH is out of bounds
//   HEIGHT        120     visible rows; y >= HEIGHT is out of bounds
//   CLEAR_COLOUR  3'b000  colour written to every pixel by a clear
// PORTS
//   clk         in   1   single clock, all state on rising edge
//   rst_n       in   1   asynchronous, active-low reset
//   vga_x       in   8   plot column
//   vga_y       in   7   plot row
//   vga_colour  in   3   plot colour
//   vga_plot    in   1   plot strobe; one pixel per cycle high
//   clr_start   in   1   level request to clear the framebuffer
//   clr_done    out  1   clear complete; held until clr_start drops
//   busy        out  1   high while in CLEAR
//   rd_req      in   1   readback request, sampled each edge
//   rd_x        in   8   readback column
//   rd_y        in   7   readback row
//   rd_valid    out  1   one-cycle pulse, 1 cycle after rd_req
//   rd_colour   out  3   readback data, valid when rd_valid
//   oob_seen    out  1   sticky: an out-of-bounds plot was dropped
// BEHAVIOUR
//   Reset values
//   - All outputs 0; FSM goes to IDLE.
//   - RAM contents are NOT reset (undefined until the first clear).
//   Addressing
//   - addr = y*WIDTH + x, 15 bits unsigned.
//   - For WIDTH=160 the address is (y<<7)+(y<<5)+x; no multiplier.
//   Plot write
//   - A plot with vga_plot=1, x<WIDTH and y<HEIGHT commits at that edge.
//   - Out-of-bounds plots are dropped and set oob_seen.
//   - oob_seen clears only on reset or on entering CLEAR.
//   FSM: IDLE -> CLEAR -> DONE -> IDLE
//   - IDLE: clr_start=1 -> CLEAR; clear counter = 0.
//   - CLEAR: writes CLEAR_COLOUR at counter, one address per cycle; busy=1.
//     - Exits after address WIDTH*HEIGHT-1, so CLEAR lasts exactly 19200 cycles.
//     - Plots arriving during CLEAR are dropped (clear owns the write port).
//     - Dropped plots do not set oob_seen.
//   - DONE: clr_done=1; clr_start=0 -> IDLE.
//     - Plots are accepted in DONE.
//     - clr_start still high keeps DONE; it does not re-clear.
//   Readback
//   - rd_req at edge N -> rd_valid=1 and rd_colour=RAM[addr] during cycle N+1.
//   - Back-to-back requests give back-to-back valids.
//   - Out-of-bounds read: rd_valid=1, rd_colour=0.
//   - Read is independent of FSM state.
//   - Read and write to the same address on the same edge: read-first, old data is returned.
//   Reset mid-CLEAR
//   - Returns to IDLE, busy=0, clr_done=0.
//   - The partially cleared RAM is left as is.
// CONFIGURATION
//   PLOT_COUNT_EN defined:
//   - Adds output plot_count[15:0]: the number of committed plots.
//   - Saturates at 16'hFFFF; resets to 0 on rst_n and on entering CLEAR.
//   - Clear writes are not counted.
//   PLOT_COUNT_EN undefined:
//   - Port and counter are absent; all other behaviour is identical.
// STRUCTURE
//   Package fb_pkg holds:
//   - FB_W, FB_H, FB_PIXELS, ADDR_W=15 constants.
//   - typedef enum {IDLE, CLEAR, DONE} clr_state_t.
//   - function fb_addr(x, y) and function in_bounds(x, y).
//   Sub-module fb_ram: simple dual-port synchronous RAM.
//   - One write port: muxed clear/plot, clear wins.
//   - One read port; read-first.
// TESTING
//   1. Reset with rst_n=0 for 2 cycles -> all outputs 0, state IDLE.
//   2. clr_start=1 -> busy for exactly 19200 cycles, then clr_done=1; drop clr_start -> clr_done=0 the next cycle.
//      A read of (159,119) afterwards -> 3'b000.
//   3. After clear, plot (10,20,3'b101) -> rd_req (10,20) gives rd_valid next cycle with rd_colour=3'b101.
//      Neighbour (11,20) reads 3'b000.
//   4. Plot (160,5) and (5,120) -> no RAM change, oob_seen=1.
//      oob_seen stays 1 until the next clr_start.
//   5. Plot (7,7,3'b111) during CLEAR -> dropped, (7,7) reads 3'b000 after done.
//      Same-edge plot + read of (1,1) -> old value returned, new value on the next read.
//   6. Assert rst_n=0 at clear cycle 5000 -> busy=0, clr_done=0, IDLE.
//      With PLOT_COUNT_EN, 3 in-bounds + 1 OOB plot give plot_count=3.

Source files
------------

// File: rtl/fb_pkg.sv
// Framebuffer geometry, clear-sequencer state type and pixel addressing helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package fb_pkg;

  localparam int FB_W      = 160;
  localparam int FB_H      = 120;
  localparam int FB_PIXELS = FB_W * FB_H;
  localparam int ADDR_W    = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  // y*160 + x built from two shifts so no multiplier is inferred.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
    return ADDR_W'({y, 7'd0}) + ADDR_W'({y, 5'd0}) + ADDR_W'(x);
  endfunction

  function automatic logic in_bounds(input logic [7:0] x, input logic [6:0] y);
    return (x < 8'(FB_W)) && (y < 7'(FB_H));
  endfunction

endpackage

// File: rtl/plot_capture_if.sv
// Pixel-plot strobe bus plus random-access readback bus of the plot sink.
// Latency: readback data is valid one cycle after rd_req.
// Backpressure: none; plots are one per cycle, reads always answered.
// master: plot source / reader (drives vga_*, rd_req/rd_x/rd_y)
// slave : plot sink (drives rd_valid/rd_colour)
interface plot_capture_if;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       rd_req;
  logic [7:0] rd_x;
  logic [6:0] rd_y;
  logic       rd_valid;
  logic [2:0] rd_colour;

  modport master (
    output vga_x, vga_y, vga_colour, vga_plot, rd_req, rd_x, rd_y,
    input  rd_valid, rd_colour
  );

  modport slave (
    input  vga_x, vga_y, vga_colour, vga_plot, rd_req, rd_x, rd_y,
    output rd_valid, rd_colour
  );
endinterface

// File: rtl/fb_ram.sv
// Simple dual-port synchronous RAM, one write port and one read port, no reset.
// Latency: 1 cycle read; a same-edge write to the read address returns old data.
// Backpressure: none.
// Ports: clk, we/waddr/wdat (write), re/raddr/rdat (read).
module fb_ram #(
  parameter int DEPTH  = 19200,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdat,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdat
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Both ports update with non-blocking assignments on the same edge, so the
  // read samples the array before the write lands (read-first).
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdat;
    if (re) rdat <= mem[raddr];
  end

endmodule

// File: rtl/plot_capture.sv
// Pixel-plot sink: stores plots into a WIDTHxHEIGHT 3-bit framebuffer, with readback and clear sequencer.
// Latency: plot commits on its edge; readback valid 1 cycle after rd_req; clear takes WIDTH*HEIGHT cycles.
// Backpressure: none; plots during a clear are dropped, clr_done held until clr_start drops.
// Ports: clk, rst_n (async active-low); bus (plot_capture_if.slave: vga_* plot strobe, rd_* readback);
//        clr_start / clr_done / busy clear handshake; oob_seen sticky out-of-bounds flag.
// Optional: define PLOT_COUNT_EN to add plot_count[15:0], a saturating count of committed plots.
module plot_capture
  import fb_pkg::*;
#(
  parameter int         WIDTH        = FB_W,
  parameter int         HEIGHT       = FB_H,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  plot_capture_if.slave        bus,
  input  logic                 clr_start,
  output logic                 clr_done,
  output logic                 busy,
  output logic                 oob_seen
`ifdef PLOT_COUNT_EN
  ,
  output logic [15:0]          plot_count
`endif
);

  localparam int                PIXELS    = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

  clr_state_t        state;
  logic [ADDR_W-1:0] clr_cnt;

  logic              plot_inb;
  logic              rd_inb;
  logic [ADDR_W-1:0] plot_addr;
  logic [ADDR_W-1:0] rd_addr;

  // Default geometry uses the shift-based helpers; any other size falls back
  // to plain arithmetic.
  generate
    if (WIDTH == FB_W && HEIGHT == FB_H) begin : g_fixed
      assign plot_inb  = in_bounds(bus.vga_x, bus.vga_y);
      assign plot_addr = fb_addr(bus.vga_x, bus.vga_y);
      assign rd_inb    = in_bounds(bus.rd_x, bus.rd_y);
      assign rd_addr   = fb_addr(bus.rd_x, bus.rd_y);
    end else begin : g_generic
      assign plot_inb  = ({24'd0, bus.vga_x} < WIDTH) && ({25'd0, bus.vga_y} < HEIGHT);
      assign plot_addr = ADDR_W'({25'd0, bus.vga_y} * WIDTH + {24'd0, bus.vga_x});
      assign rd_inb    = ({24'd0, bus.rd_x} < WIDTH) && ({25'd0, bus.rd_y} < HEIGHT);
      assign rd_addr   = ADDR_W'({25'd0, bus.rd_y} * WIDTH + {24'd0, bus.rd_x});
    end
  endgenerate

  logic entering_clear;
  logic clearing;
  logic plot_commit;
  logic plot_oob;

  assign entering_clear = (state == IDLE) && clr_start;
  assign clearing       = (state == CLEAR);
  // The clear owns the write port: plots seen while clearing are discarded
  // without touching oob_seen.
  assign plot_commit    = bus.vga_plot && plot_inb && !clearing;
  assign plot_oob       = bus.vga_plot && !plot_inb && !clearing;

  assign busy     = clearing;
  assign clr_done = (state == DONE);

  // Clear sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_start) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (clr_cnt == LAST_ADDR) state <= DONE;
        end
        DONE: begin
          // A held request does not retrigger; it must drop first.
          if (!clr_start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              oob_seen <= 1'b0;
    else if (entering_clear) oob_seen <= 1'b0;
    else if (plot_oob)       oob_seen <= 1'b1;
  end

`ifdef PLOT_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      plot_count <= '0;
    else if (entering_clear)
      plot_count <= '0;
    else if (plot_commit && (plot_count != 16'hFFFF))
      plot_count <= plot_count + 16'd1;
  end
`endif

  // Write port mux: clear wins over plots.
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [2:0]        ram_wdat;
  logic [2:0]        ram_rdat;

  always_comb begin
    ram_we    = plot_commit;
    ram_waddr = plot_addr;
    ram_wdat  = bus.vga_colour;
    if (clearing) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt;
      ram_wdat  = CLEAR_COLOUR;
    end
  end

  fb_ram #(
    .DEPTH  (PIXELS),
    .ADDR_W (ADDR_W),
    .DATA_W (3)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdat  (ram_wdat),
    .re    (bus.rd_req && rd_inb),
    .raddr (rd_addr),
    .rdat  (ram_rdat)
  );

  // The RAM output register has no reset, so the visible colour is gated by
  // registered valid/in-bounds flags; this also forces 0 for out-of-bounds reads.
  logic rd_valid_q;
  logic rd_inb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_inb_q   <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_req;
      rd_inb_q   <= bus.rd_req && rd_inb;
    end
  end

  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_colour = (rd_valid_q && rd_inb_q) ? ram_rdat : 3'b000;

endmodule

// File: tb/tb_plot_capture.sv
// Self-checking bench for plot_capture: framebuffer model, clear timing, readback scoreboard.
// Latency: expects read data one cycle after each request.
// Backpressure: none exercised; the DUT never stalls.
module tb_plot_capture;

  localparam int W = 160;
  localparam int H = 120;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clr_start = 1'b0;
  logic clr_done;
  logic busy;
  logic oob_seen;
`ifdef PLOT_COUNT_EN
  logic [15:0] plot_count;
`endif

  plot_capture_if bus ();

  always #5 clk = ~clk;

  plot_capture dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clr_start (clr_start),
    .clr_done  (clr_done),
    .busy      (busy),
    .oob_seen  (oob_seen)
`ifdef PLOT_COUNT_EN
    ,
    .plot_count(plot_count)
`endif
  );

  typedef struct {
    int cyc;
    int val;   // -1: value not known, colour not compared
  } exp_t;

  exp_t q[$];
  int   model [W*H];   // -1: pixel contents unknown
  bit   m_oob;
  int   m_count;
  bit   m_clear;
  int   cyc;
  int   n_cmp;
  int   n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("rd_valid", {31'd0, bus.rd_valid}, 32'd1);
      if (e.val >= 0) chk("rd_colour", {29'd0, bus.rd_colour}, e.val);
    end else begin
      chk("rd_valid_idle", {31'd0, bus.rd_valid}, 32'd0);
    end
  end

  // One clock of stimulus. Expected read data is taken from the model before
  // this cycle's plot is applied, which is what a read-first memory returns.
  task automatic cycle(input bit p, input int px, input int py, input int pc,
                       input bit r, input int rx, input int ry);
    exp_t e;
    bus.vga_plot   = p;
    bus.vga_x      = 8'(px);
    bus.vga_y      = 7'(py);
    bus.vga_colour = 3'(pc);
    bus.rd_req     = r;
    bus.rd_x       = 8'(rx);
    bus.rd_y       = 7'(ry);
    if (r) begin
      e.cyc = cyc + 1;
      e.val = (rx < W && ry < H) ? model[ry*W + rx] : 0;
      q.push_back(e);
    end
    if (p && !m_clear) begin
      if (px < W && py < H) begin
        model[py*W + px] = pc;
        if (m_count < 65535) m_count++;
      end else begin
        m_oob = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input int rx, input int ry);
    cycle(0, 0, 0, 0, 1, rx, ry);
  endtask

  task automatic plot(input int px, input int py, input int pc);
    cycle(1, px, py, pc, 0, 0, 0);
  endtask

  task automatic do_clear(input bit plot_during);
    int n;
    n = 0;
    clr_start = 1'b1;
    idle();
    m_oob   = 1'b0;
    m_count = 0;
    m_clear = 1'b1;
    while (busy === 1'b1 && n < 20000) begin
      n++;
      if (plot_during && n == 100)      cycle(1, 7, 7, 7, 0, 0, 0);
      else if (plot_during && n == 200) cycle(1, 200, 5, 1, 0, 0, 0);
      else                              idle();
    end
    m_clear = 1'b0;
    foreach (model[i]) model[i] = 0;
    chk("clear_busy_cycles", n, 20000 - 800);
    chk("clr_done_after_clear", {31'd0, clr_done}, 32'd1);
    chk("oob_after_clear", {31'd0, oob_seen}, {31'd0, m_oob});
    repeat (3) idle();
    chk("clr_done_held", {31'd0, clr_done}, 32'd1);
    chk("busy_low_in_done", {31'd0, busy}, 32'd0);
    clr_start = 1'b0;
    idle();
    chk("clr_done_dropped", {31'd0, clr_done}, 32'd0);
  endtask

  task automatic check_count();
`ifdef PLOT_COUNT_EN
    chk("plot_count", {16'd0, plot_count}, m_count);
`endif
  endtask

  initial begin
    int p, px, py, pc, r, rx, ry;
    bus.vga_plot = 0; bus.vga_x = 0; bus.vga_y = 0; bus.vga_colour = 0;
    bus.rd_req = 0; bus.rd_x = 0; bus.rd_y = 0;
    foreach (model[i]) model[i] = -1;
    m_oob = 0; m_count = 0; m_clear = 0;

    // Reset
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_clr_done", {31'd0, clr_done}, 32'd0);
    chk("rst_oob", {31'd0, oob_seen}, 32'd0);
    chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("rst_rd_colour", {29'd0, bus.rd_colour}, 32'd0);
    check_count();
    rst_n = 1'b1;
    idle();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_clr_done", {31'd0, clr_done}, 32'd0);

    // First clear, with an in-bounds and an out-of-bounds plot during it
    do_clear(1'b1);
    rd(159, 119);
    rd(7, 7);
    idle();

    // Directed plots and readback
    plot(10, 20, 5);
    rd(10, 20);
    rd(11, 20);
    cycle(1, 1, 1, 6, 1, 1, 1);   // same-edge plot and read
    rd(1, 1);
    idle();
    chk("oob_still_clear", {31'd0, oob_seen}, 32'd0);
    plot(160, 5, 7);
    plot(5, 120, 7);
    rd(0, 6);                     // where a wrapped (160,5) would land
    rd(200, 3);                   // out-of-bounds read
    idle();
    chk("oob_set", {31'd0, oob_seen}, 32'd1);
    plot(159, 119, 3);
    rd(159, 119);
    check_count();

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      p  = int'($urandom_range(0, 1));
      px = int'($urandom_range(0, 175));
      py = int'($urandom_range(0, 127));
      pc = int'($urandom_range(0, 7));
      r  = int'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        rx = px; ry = py;
      end else begin
        rx = int'($urandom_range(0, 170));
        ry = int'($urandom_range(0, 125));
      end
      cycle(p[0], px, py, pc, r[0], rx, ry);
    end
    idle();
    chk("oob_after_random", {31'd0, oob_seen}, {31'd0, m_oob});
    check_count();

    // Second clear: sticky flag drops, counter restarts
    do_clear(1'b0);
    plot(2, 3, 1);
    plot(4, 5, 2);
    plot(159, 119, 4);
    plot(200, 3, 1);
    idle();
    chk("oob_after_second", {31'd0, oob_seen}, 32'd1);
    check_count();
    rd(2, 3);
    rd(4, 5);
    rd(159, 119);
    idle();

    // Reset in the middle of a clear
    clr_start = 1'b1;
    idle();
    m_clear = 1'b1;
    clr_start = 1'b0;
    for (int k = 0; k < 5000; k++) idle();
    chk("busy_mid_clear", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_clr_done", {31'd0, clr_done}, 32'd0);
    chk("midrst_oob", {31'd0, oob_seen}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_clear = 1'b0; m_oob = 1'b0; m_count = 0;
    for (int i = 0; i < 5011; i++) model[i] = (i < 4990) ? 0 : -1;
    idle();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_clr_done", {31'd0, clr_done}, 32'd0);
    check_count();
    rd(159, 119);   // beyond the cleared region: keeps its colour
    rd(2, 3);       // inside the cleared region
    rd(100, 100);
    repeat (3) idle();
    chk("queue_drained", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
